// File: rtl/nabp_sinogram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nabp_sinogram_arbiter_pkg
// Description : Shared widths for the sinogram read path and a small
//               modulo-N helper used by the round-robin search.
//               kDataLength            sinogram value width
//               kSinogramAddressLength sinogram RAM/LUT address width
// Revision    : 1.0  initial release
// ============================================================================
package nabp_sinogram_arbiter_pkg;

  localparam int kDataLength            = 16;
  localparam int kSinogramAddressLength = 12;

  // (a + b) mod n for 0 <= a, b < n; avoids a real divider when n is not a
  // power of two.
  function automatic int rr_add_wrap(input int a, input int b, input int n);
    int sum;
    sum = a + b;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage : nabp_sinogram_arbiter_pkg
`default_nettype wire

// File: rtl/nabp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nabp_rr_arbiter
// Description : Round-robin arbiter. Searches req upward from the pointer,
//               wrapping N-1 -> 0; the first set bit wins. The pointer moves
//               to one past the winner, or holds when nothing is granted.
// Ports       : clk      clock, rising edge
//               reset_n  asynchronous active-low reset
//               req      request vector
//               gnt      one-hot grant (combinational, zero when req == 0)
//               gnt_idx  binary index of the granted requester
// Revision    : 1.0  initial release
// ============================================================================
module nabp_rr_arbiter
  import nabp_sinogram_arbiter_pkg::*;
#(
  parameter int kNumReq = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [kNumReq-1:0]         req,
  output logic [kNumReq-1:0]         gnt,
  output logic [$clog2(kNumReq)-1:0] gnt_idx
);

  localparam int                   kPtrWidth = $clog2(kNumReq);
  localparam logic [kPtrWidth-1:0] kLastIdx  = kPtrWidth'(kNumReq - 1);

  logic [kPtrWidth-1:0] ptr_d, ptr_q;
  logic                 gnt_found;

  always_comb begin
    logic [kPtrWidth-1:0] cand;
    cand      = '0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < kNumReq; k++) begin
      cand = kPtrWidth'(rr_add_wrap(int'(ptr_q), k, kNumReq));
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end

    // Wrap by compare so a non-power-of-two N never reaches an unused index.
    ptr_d = ptr_q;
    if (gnt_found) begin
      ptr_d = (gnt_idx == kLastIdx) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : nabp_rr_arbiter
`default_nettype wire

// File: rtl/nabp_sinogram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nabp_sinogram_arbiter
// Description : Shares the single read port of the sinogram RAM/LUT among
//               kNumReq back-projection lanes. One read is granted per cycle
//               (round robin), its address is registered onto sg_addr, and
//               the returning value is handed back to the issuing lane with
//               a one-hot rsp_valid after a fixed kReadLatency+1 edges.
// Ports       : clk        clock, rising edge
//               reset_n    asynchronous active-low reset
//               req_valid  per-lane read pending
//               req_addr   per-lane address, lane i at [i*A +: A]
//               req_ready  one-hot grant, combinational
//               sg_addr    registered address to the sinogram RAM
//               sg_val     RAM read data
//               rsp_valid  one-hot owner of rsp_val
//               rsp_val    returned sinogram value
//               busy       a read is pending or in flight
// Revision    : 1.0  initial release
// ============================================================================
module nabp_sinogram_arbiter
  import nabp_sinogram_arbiter_pkg::*;
#(
  parameter int kNumReq      = 4,
  parameter int kAddrWidth   = kSinogramAddressLength,
  parameter int kDataWidth   = kDataLength,
  parameter int kReadLatency = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [kNumReq-1:0]            req_valid,
  input  logic [kNumReq*kAddrWidth-1:0] req_addr,
  output logic [kNumReq-1:0]            req_ready,
  output logic [kAddrWidth-1:0]         sg_addr,
  input  logic [kDataWidth-1:0]         sg_val,
  output logic [kNumReq-1:0]            rsp_valid,
  output logic [kDataWidth-1:0]         rsp_val,
  output logic                          busy
);

  localparam int kPtrWidth  = $clog2(kNumReq);
  // Stage 0 is loaded on the grant edge (same edge as sg_addr); the last
  // stage lines up with sg_val becoming valid, so rsp_valid and rsp_val are
  // captured together on the following edge.
  localparam int kTagStages = kReadLatency + 1;

  logic [kNumReq-1:0]    gnt;
  logic [kPtrWidth-1:0]  gnt_idx;
  logic [kAddrWidth-1:0] addr_lane [kNumReq];

  logic [kAddrWidth-1:0]                 sg_addr_d, sg_addr_q;
  logic [kTagStages-1:0][kNumReq-1:0]    tag_d, tag_q;
  logic [kNumReq-1:0]                    rsp_valid_d, rsp_valid_q;
  logic [kDataWidth-1:0]                 rsp_val_d, rsp_val_q;

  nabp_rr_arbiter #(
    .kNumReq (kNumReq)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  always_comb begin
    for (int i = 0; i < kNumReq; i++) begin
      addr_lane[i] = req_addr[i*kAddrWidth +: kAddrWidth];
    end

    sg_addr_d = sg_addr_q;
    if (|gnt) begin
      sg_addr_d = addr_lane[gnt_idx];
    end

    // The one-hot grant doubles as the tag: non-zero means a valid read.
    tag_d       = {tag_q[kTagStages-2:0], gnt};
    rsp_valid_d = tag_q[kTagStages-1];
    rsp_val_d   = sg_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sg_addr_q   <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_val_q   <= '0;
    end else begin
      sg_addr_q   <= sg_addr_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_val_q   <= rsp_val_d;
    end
  end

  assign sg_addr   = sg_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_val   = rsp_val_q;
  assign busy      = (|req_valid) | (|tag_q);

endmodule : nabp_sinogram_arbiter
`default_nettype wire

// File: tb/tb_nabp_sinogram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nabp_sinogram_arbiter
// Description : Self-checking bench for nabp_sinogram_arbiter. A queue-based
//               reference model is compared against the DUT every cycle, and
//               directed scenarios pin grant order and returned values with
//               hand-computed literals.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nabp_sinogram_arbiter;
  import nabp_sinogram_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = kSinogramAddressLength;
  localparam int DW = kDataLength;
  localparam int L  = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_ready;
  logic [AW-1:0] sg_addr;
  logic [DW-1:0] sg_val;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_val;
  logic          busy;

  always #5 clk = ~clk;

  nabp_sinogram_arbiter #(
    .kNumReq      (N),
    .kAddrWidth   (AW),
    .kDataWidth   (DW),
    .kReadLatency (L)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .sg_addr   (sg_addr),
    .sg_val    (sg_val),
    .rsp_valid (rsp_valid),
    .rsp_val   (rsp_val),
    .busy      (busy)
  );

  // LUT contents: value = 3*addr + 1
  function automatic logic [DW-1:0] lut(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = DW'(a);
    return t * DW'(3) + DW'(1);
  endfunction

  // Sinogram RAM model with L cycles of read latency.
  logic [DW-1:0] ram_pipe [L];
  always @(posedge clk) begin
    ram_pipe[0] <= lut(sg_addr);
    for (int k = 1; k < L; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign sg_val = ram_pipe[L-1];

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    int            lane;
    logic [DW-1:0] val;
    int            due;
  } exp_t;

  exp_t          mq[$];
  int            m_ptr = 0;
  logic [AW-1:0] m_addr = '0;
  int            cyc = 0;
  int            n_issued = 0;
  int            n_returned = 0;

  // Logs of what the DUT did, used by the directed literal checks.
  int            glog[$];
  logic [N-1:0]  rlog_vec[$];
  logic [DW-1:0] rlog_val[$];
  int            rlog_cyc[$];

  // Reference model and per-cycle compare. Inputs only change just after a
  // rising edge, so the values seen at the falling edge are the ones the
  // next rising edge will act upon.
  initial begin
    logic [N-1:0]  exp_rv;
    logic [N-1:0]  exp_rdy;
    int            g;
    logic [AW-1:0] a;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mq.delete();
        m_ptr  = 0;
        m_addr = '0;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_val",   64'(rsp_val),   64'(0));
        chk("rst_sg_addr",   64'(sg_addr),   64'(0));
        chk("rst_busy",      64'(busy),      64'(|req_valid));
      end else begin
        exp_rv = '0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
          exp_rv[mq[0].lane] = 1'b1;
          chk("rsp_val", 64'(rsp_val), 64'(mq[0].val));
          void'(mq.pop_front());
          n_returned++;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (rsp_valid != '0) begin
          rlog_vec.push_back(rsp_valid);
          rlog_val.push_back(rsp_val);
          rlog_cyc.push_back(cyc);
        end
        chk("sg_addr", 64'(sg_addr), 64'(m_addr));
        chk("busy", 64'(busy), 64'((|req_valid) || (mq.size() > 0)));

        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (req_ready != '0) glog.push_back(onehot_idx(req_ready));

        if (g >= 0) begin
          a = req_addr[g*AW +: AW];
          e.lane = g;
          e.val  = lut(a);
          e.due  = cyc + L + 2;
          mq.push_back(e);
          m_addr = a;
          m_ptr  = (g + 1) % N;
          n_issued++;
        end
      end
      cyc++;
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [AW-1:0] lane_mem [N][8];
  int            lane_n [N];
  int            lane_i [N];
  bit            rnd_mode = 1'b0;
  bit            rnd_stop = 1'b0;

  // Presents the next item per lane; a lane holds its request until accepted.
  task automatic apply(input logic [N-1:0] acc);
    for (int i = 0; i < N; i++) begin
      if (rnd_mode) begin
        if (acc[i] || !req_valid[i]) begin
          if (!rnd_stop && $urandom_range(0, 1) == 1) begin
            req_valid[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'($urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end else begin
        if (acc[i]) lane_i[i]++;
        if (lane_i[i] < lane_n[i]) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = lane_mem[i][lane_i[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready & {N{reset_n}};
    @(posedge clk);
    #1;
    apply(acc);
  endtask

  task automatic load_lane(input int i, input int n, input int base);
    lane_n[i] = n;
    lane_i[i] = 0;
    for (int k = 0; k < n; k++) lane_mem[i][k] = AW'(base + k);
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < N; i++) begin
      lane_n[i] = 0;
      lane_i[i] = 0;
    end
  endtask

  task automatic clear_logs();
    glog.delete();
    rlog_vec.delete();
    rlog_val.delete();
    rlog_cyc.delete();
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((req_valid != '0 || mq.size() > 0) && t < 200) begin
      step();
      t++;
    end
    chk(name, 64'(t < 200), 64'(1));
  endtask

  function automatic int gat(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  function automatic int rval(input int k);
    return (k < rlog_val.size()) ? int'(rlog_val[k]) : -1;
  endfunction

  function automatic int rlane(input int k);
    return (k < rlog_vec.size()) ? onehot_idx(rlog_vec[k]) : -1;
  endfunction

  int t2_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int t2_v[8] = '{1, 49, 97, 145, 4, 52, 100, 148};
  int t3_v[3] = '{16, 19, 22};

  initial begin
    clear_lanes();

    // 1: reset held with all lanes requesting
    for (int i = 0; i < N; i++) load_lane(i, 1, 100 + i);
    #1 reset_n = 1'b0;
    apply('0);
    step();
    step();
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t1_sg_addr",   64'(sg_addr),   64'(0));
    chk("t1_busy",      64'(busy),      64'(1));
    @(posedge clk);
    #1;
    clear_logs();
    reset_n = 1'b1;
    drain("t1_drain");
    chk("t1_first_grant", 64'(gat(0)), 64'(0));
    chk("t1_ngrants", 64'(glog.size()), 64'(4));

    // 2: all lanes valid for 8 cycles, two reads each
    clear_logs();
    for (int i = 0; i < N; i++) load_lane(i, 2, 16 * i);
    apply('0);
    drain("t2_drain");
    for (int k = 0; k < 8; k++) chk("t2_grant", 64'(gat(k)), 64'(t2_g[k]));
    for (int k = 0; k < 8; k++) chk("t2_rsp_lane", 64'(rlane(k)), 64'(t2_g[k]));
    for (int k = 0; k < 8; k++) chk("t2_rsp_val", 64'(rval(k)), 64'(t2_v[k]));

    // 3: lone requester at full rate
    clear_logs();
    clear_lanes();
    load_lane(2, 3, 5);
    apply('0);
    drain("t3_drain");
    chk("t3_ngrants", 64'(glog.size()), 64'(3));
    for (int k = 0; k < 3; k++) begin
      chk("t3_rsp_vec", 64'((k < rlog_vec.size()) ? rlog_vec[k] : 4'b0000), 64'(4'b0100));
      chk("t3_rsp_val", 64'(rval(k)), 64'(t3_v[k]));
    end
    chk("t3_consecutive", 64'((rlog_cyc.size() == 3) ? rlog_cyc[2] - rlog_cyc[0] : -1), 64'(2));

    // 4: pointer at 3 after lane 2; lanes 1 and 3 -> 3 then 1, pointer now 2
    clear_logs();
    clear_lanes();
    load_lane(1, 1, 200);
    load_lane(3, 1, 300);
    apply('0);
    drain("t4_drain");
    chk("t4_grant0", 64'(gat(0)), 64'(3));
    chk("t4_grant1", 64'(gat(1)), 64'(1));
    clear_logs();
    for (int i = 0; i < N; i++) load_lane(i, 1, 400 + i);
    apply('0);
    drain("t4b_drain");
    chk("t4_ptr_after", 64'(gat(0)), 64'(2));

    // 5: reset one cycle after a grant discards the in-flight read
    clear_lanes();
    load_lane(0, 1, 9);
    apply('0);
    step();
    step();
    reset_n = 1'b0;
    clear_logs();
    step();
    step();
    reset_n = 1'b1;
    repeat (4) step();
    chk("t5_no_rsp", 64'(rlog_vec.size()), 64'(0));
    clear_logs();
    for (int i = 0; i < N; i++) load_lane(i, 1, 500 + i);
    apply('0);
    drain("t5_drain");
    chk("t5_first_grant", 64'(gat(0)), 64'(0));

    // 6: random traffic against the model
    clear_lanes();
    n_issued   = 0;
    n_returned = 0;
    rnd_mode   = 1'b1;
    rnd_stop   = 1'b0;
    repeat (10000) step();
    rnd_stop = 1'b1;
    drain("t6_drain");
    step();
    chk("t6_all_returned", 64'(n_returned), 64'(n_issued));
    chk("t6_traffic", 64'(n_issued > 1000), 64'(1));
    chk("t6_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule : tb_nabp_sinogram_arbiter
`default_nettype wire
